// File: rtl/fifo_drain_control.sv
// De-skews the result columns leaving the systolic MMU: per-column output FIFO write
// enables over a RUN window, followed by a one-cycle done pulse.
module fifo_drain_control #(
    parameter int WIDTH   = 16,
    parameter int ROWS    = 16,
    parameter int LATENCY = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             stagger_drain,
    input  logic             stall,
    output logic [WIDTH-1:0] wr_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int          TW          = $clog2(LATENCY + ROWS + WIDTH + 1);
    localparam logic [31:0] T_LAST_FLAT = 32'(LATENCY + ROWS - 1);
    localparam logic [31:0] T_LAST_STAG = 32'(LATENCY + ROWS + WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_nxt;
    logic            r_mode;
    logic            w_mode_nxt;
    logic [31:0]     w_t32;
    logic [31:0]     w_t_last;
    logic [31:0]     w_lo;

    // Handshake: active is a level request honoured only while IDLE; stall is a
    // same-cycle "not ready" that blanks wr_en and freezes t and state.
    assign w_t32     = 32'(r_t);
    assign w_t_last  = r_mode ? T_LAST_STAG : T_LAST_FLAT;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign state_dbg = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_mode_nxt  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (active) begin
                    w_state_nxt = S_RUN;
                    w_t_nxt     = '0;
                    w_mode_nxt  = stagger_drain;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (w_t32 == w_t_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_t_nxt = r_t + TW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    // Column j's window opens LATENCY (+j when staggered) cycles into RUN and lasts ROWS.
    always_comb begin
        wr_en = '0;
        w_lo  = '0;
        if (r_state == S_RUN && !stall) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_lo     = 32'(LATENCY) + (r_mode ? 32'(j) : 32'd0);
                wr_en[j] = (w_t32 >= w_lo) && (w_t32 <= w_lo + 32'(ROWS - 1));
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_control.sv
// Directed bench for fifo_drain_control: a small 4/3/2 instance checked cycle by cycle
// against an expected queue, plus spot checks on a default-parameter instance.
module tb_fifo_drain_control;

    localparam int W = 4;
    localparam int R = 3;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         active = 1'b0;
    logic         stagger = 1'b0;
    logic         stall = 1'b0;
    logic [W-1:0] wr_en;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    logic         d_active = 1'b0;
    logic         d_stagger = 1'b0;
    logic [15:0]  d_wr_en;
    logic         d_busy;
    logic         d_done;
    logic [1:0]   d_state_dbg;

    int           tests = 0;
    int           fails = 0;
    string        cur_tag = "reset";
    logic [W+1:0] exp_q[$];
    int           cnt[W];
    logic [3:0]   tab1[8];
    logic [3:0]   tabf[5];

    fifo_drain_control #(.WIDTH(W), .ROWS(R), .LATENCY(L)) dut (
        .clk(clk), .reset(reset), .active(active), .stagger_drain(stagger), .stall(stall),
        .wr_en(wr_en), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    fifo_drain_control dut_d (
        .clk(clk), .reset(reset), .active(d_active), .stagger_drain(d_stagger), .stall(1'b0),
        .wr_en(d_wr_en), .busy(d_busy), .done(d_done), .state_dbg(d_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (inputs set just after the edge), compare against the queue head.
    task automatic tick(input logic a, input logic s, input logic r);
        logic [W+1:0] e;
        active = a;
        stall  = s;
        reset  = r;
        #2;
        if (exp_q.size() == 0) begin
            check({cur_tag, "_queue_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(cur_tag, {26'd0, wr_en, busy, done}, {26'd0, e});
        end
        for (int j = 0; j < W; j++) cnt[j] += int'(wr_en[j]);
        @(posedge clk);
        #1;
    endtask

    function automatic void push_idle();
        exp_q.push_back('0);
    endfunction

    function automatic void push_done();
        exp_q.push_back({{W{1'b0}}, 1'b0, 1'b1});
    endfunction

    function automatic void push_tab1(input int n_run);
        for (int t = 0; t < n_run; t++) exp_q.push_back({tab1[t], 1'b1, 1'b0});
        if (n_run == 8) push_done();
    endfunction

    function automatic logic [W-1:0] wr_model(input logic mode, input int t);
        logic [W-1:0] v;
        int lo;
        v = '0;
        for (int j = 0; j < W; j++) begin
            lo   = L + (mode ? j : 0);
            v[j] = (t >= lo) && (t <= lo + R - 1);
        end
        return v;
    endfunction

    // RUN cycles plus the DONE cycle for a drain with the given per-RUN-cycle stall mask.
    function automatic void push_model(input logic mode, input logic [31:0] smask);
        int t;
        int last;
        t    = 0;
        last = mode ? (L + R - 1 + W - 1) : (L + R - 1);
        for (int k = 0; k < 32; k++) begin
            if (smask[k]) begin
                exp_q.push_back({{W{1'b0}}, 1'b1, 1'b0});
            end else begin
                exp_q.push_back({wr_model(mode, t), 1'b1, 1'b0});
                if (t == last) break;
                t++;
            end
        end
        push_done();
    endfunction

    task automatic clear_cnt();
        for (int j = 0; j < W; j++) cnt[j] = 0;
    endtask

    task automatic check_cnt(input string tag);
        for (int j = 0; j < W; j++) check(tag, 32'(cnt[j]), 32'(R));
    endtask

    task automatic run_stagger_full();
        clear_cnt();
        stagger = 1'b1;
        push_idle();
        push_tab1(8);
        push_idle();
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        check_cnt({cur_tag, "_count"});
    endtask

    initial begin
        tab1 = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8};
        tabf = '{4'h0, 4'h0, 4'hf, 4'hf, 4'hf};
        clear_cnt();

        @(posedge clk);
        #1;
        check("reset_state", 32'(state_dbg), 32'd0);
        push_idle();
        push_idle();
        push_idle();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        cur_tag = "stagger";
        run_stagger_full();

        cur_tag = "flat";
        stagger = 1'b0;
        push_idle();
        push_idle();
        for (int t = 0; t < 5; t++) exp_q.push_back({tabf[t], 1'b1, 1'b0});
        push_done();
        push_idle();
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        stagger = 1'b1;
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0);

        cur_tag = "stall";
        clear_cnt();
        stagger = 1'b1;
        push_idle();
        push_model(1'b1, 32'h4);
        push_idle();
        push_idle();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) tick(k == 4, k == 2, 1'b0);
        check_cnt("stall_count");

        cur_tag = "reset_mid_run";
        push_idle();
        push_tab1(5);
        push_idle();
        push_idle();
        push_idle();
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        cur_tag = "after_reset";
        run_stagger_full();

        cur_tag = "active_held";
        stagger = 1'b1;
        push_idle();
        push_tab1(8);
        push_idle();
        push_tab1(8);
        push_idle();
        push_idle();
        for (int i = 0; i < 11; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        d_stagger = 1'b1;
        for (int c = 0; c < 50; c++) begin
            d_active = (c == 0);
            #2;
            if (c == 16) check("dflt_t15", {15'd0, d_wr_en, d_busy}, {15'd0, 16'h0000, 1'b1});
            if (c == 17) check("dflt_t16", {15'd0, d_wr_en, d_busy}, {15'd0, 16'h0001, 1'b1});
            if (c == 47) check("dflt_t46", {15'd0, d_wr_en, d_busy}, {15'd0, 16'h8000, 1'b1});
            if (c == 48) check("dflt_done", {14'd0, d_wr_en, d_busy, d_done}, {14'd0, 16'h0000, 1'b0, 1'b1});
            if (c == 49) check("dflt_idle", {14'd0, d_wr_en, d_busy, d_done}, 32'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
